// File: rtl/pitch_glide.sv
// Per-voice pitch slew (portamento) engine: one voice is visited per clock in
// round-robin order and its current pitch is stepped toward its target.
module pitch_glide #(
  parameter int VOICES  = 8,
  parameter int V_WIDTH = 3,
  parameter int P_WIDTH = 24
) (
  input  logic                 reg_clk,
  input  logic                 reset,
  input  logic                 tgt_valid,
  input  logic [V_WIDTH-1:0]   tgt_voice,
  input  logic [P_WIDTH-1:0]   tgt_pitch,
  input  logic                 tgt_legato,
  input  logic                 com_sel,
  input  logic                 write,
  input  logic                 read,
  input  logic [6:0]           adr,
  input  logic [7:0]           synth_data_in,
  output logic [7:0]           regdata_out,
  output logic                 out_valid,
  output logic [V_WIDTH-1:0]   out_voice,
  output logic [P_WIDTH-1:0]   out_pitch,
  output logic [VOICES-1:0]    gliding
);

  localparam logic [6:0] ADR_TIME = 7'd8;
  localparam logic [6:0] ADR_MODE = 7'd9;

  logic [P_WIDTH-1:0] cur [VOICES];
  logic [P_WIDTH-1:0] tgt [VOICES];
  logic [VOICES-1:0]  init;

  logic [3:0]         glide_time;
  logic [1:0]         glide_mode;
  logic [V_WIDTH-1:0] vcnt;

  logic [P_WIDTH-1:0] slot_cur;
  logic [P_WIDTH-1:0] slot_tgt;
  logic signed [P_WIDTH:0] diff;
  logic [P_WIDTH-1:0] mag;
  logic [P_WIDTH-1:0] step;
  logic [P_WIDTH-1:0] step_cur;
  logic [P_WIDTH-1:0] load_cur;
  logic [P_WIDTH-1:0] slot_out;
  logic               load_ok;
  logic               load_jump;
  logic               mode_off;
  logic               collision;
  logic               unused_bits;

  assign unused_bits = &{1'b0, synth_data_in[7:4]};

  // The step is a fraction of the remaining distance, never less than one
  // unit and never more than the distance itself, so the target is never overshot.
  always_comb begin
    slot_cur = cur[vcnt];
    slot_tgt = tgt[vcnt];
    diff     = $signed({1'b0, slot_tgt}) - $signed({1'b0, slot_cur});
    mag      = diff[P_WIDTH] ? P_WIDTH'(-diff) : diff[P_WIDTH-1:0];
    step     = mag >> glide_time;
    if (step == '0 && diff != '0) begin
      step = P_WIDTH'(1);
    end
    step_cur = diff[P_WIDTH] ? (slot_cur - step) : (slot_cur + step);
  end

  always_comb begin
    load_ok   = tgt_valid && (int'(tgt_voice) < VOICES);
    mode_off  = (glide_mode == 2'd0) || (glide_mode == 2'd3);
    load_jump = mode_off || !init[tgt_voice] || (glide_mode == 2'd2 && !tgt_legato);
    load_cur  = load_jump ? tgt_pitch : cur[tgt_voice];
    collision = load_ok && (tgt_voice == vcnt);
    slot_out  = collision ? load_cur : step_cur;
  end

  always_ff @(posedge reg_clk) begin
    if (reset) begin
      glide_time  <= '0;
      glide_mode  <= '0;
      regdata_out <= '0;
    end else begin
      if (com_sel && write) begin
        if (adr == ADR_TIME) begin
          glide_time <= synth_data_in[3:0];
        end else if (adr == ADR_MODE) begin
          glide_mode <= synth_data_in[1:0];
        end
      end
      if (com_sel && read) begin
        if (adr == ADR_TIME) begin
          regdata_out <= {4'b0000, glide_time};
        end else if (adr == ADR_MODE) begin
          regdata_out <= {6'b000000, glide_mode};
        end
      end
    end
  end

  // A target load on the slot being visited wins; the step is skipped that cycle.
  always_ff @(posedge reg_clk) begin
    if (reset) begin
      for (int v = 0; v < VOICES; v++) begin
        cur[v] <= '0;
        tgt[v] <= '0;
      end
      init      <= '0;
      gliding   <= '0;
      vcnt      <= '0;
      out_valid <= 1'b0;
      out_voice <= '0;
      out_pitch <= '0;
    end else begin
      if (int'(vcnt) == VOICES - 1) begin
        vcnt <= '0;
      end else begin
        vcnt <= vcnt + V_WIDTH'(1);
      end

      out_valid <= 1'b1;
      out_voice <= vcnt;
      out_pitch <= slot_out;

      if (!collision) begin
        cur[vcnt]     <= step_cur;
        gliding[vcnt] <= (step_cur != slot_tgt);
      end

      if (load_ok) begin
        tgt[tgt_voice]     <= tgt_pitch;
        init[tgt_voice]    <= 1'b1;
        cur[tgt_voice]     <= load_cur;
        gliding[tgt_voice] <= (load_cur != tgt_pitch);
      end
    end
  end

endmodule

// File: tb/tb_pitch_glide.sv
// Scoreboard bench for pitch_glide: stimulus pushes hand-computed per-voice
// expectations, a negedge monitor pops them as the matching voice appears.
module tb_pitch_glide;

  localparam int VOICES  = 8;
  localparam int V_WIDTH = 3;
  localparam int P_WIDTH = 24;

  logic               reg_clk = 1'b0;
  logic               reset = 1'b1;
  logic               tgt_valid = 1'b0;
  logic [V_WIDTH-1:0] tgt_voice = '0;
  logic [P_WIDTH-1:0] tgt_pitch = '0;
  logic               tgt_legato = 1'b0;
  logic               com_sel = 1'b0;
  logic               write = 1'b0;
  logic               read = 1'b0;
  logic [6:0]         adr = '0;
  logic [7:0]         synth_data_in = '0;
  logic [7:0]         regdata_out;
  logic               out_valid;
  logic [V_WIDTH-1:0] out_voice;
  logic [P_WIDTH-1:0] out_pitch;
  logic [VOICES-1:0]  gliding;

  int checks = 0;
  int errors = 0;
  int nextSlot = 0;

  typedef struct {
    logic [V_WIDTH-1:0] voice;
    logic [P_WIDTH-1:0] pitch;
    logic               glide;
    string              name;
  } exp_t;

  exp_t sb[$];

  // Voice 1 gliding 0x400 -> 0x800 with glide_time 2, one entry per visit.
  logic [P_WIDTH-1:0] glideSeq [26] = '{
    24'h000500, 24'h0005C0, 24'h000650, 24'h0006BC, 24'h00070D, 24'h000749,
    24'h000776, 24'h000798, 24'h0007B2, 24'h0007C5, 24'h0007D3, 24'h0007DE,
    24'h0007E6, 24'h0007EC, 24'h0007F1, 24'h0007F4, 24'h0007F7, 24'h0007F9,
    24'h0007FA, 24'h0007FB, 24'h0007FC, 24'h0007FD, 24'h0007FE, 24'h0007FF,
    24'h000800, 24'h000800
  };

  pitch_glide #(.VOICES(VOICES), .V_WIDTH(V_WIDTH), .P_WIDTH(P_WIDTH)) dut (
    .reg_clk       (reg_clk),
    .reset         (reset),
    .tgt_valid     (tgt_valid),
    .tgt_voice     (tgt_voice),
    .tgt_pitch     (tgt_pitch),
    .tgt_legato    (tgt_legato),
    .com_sel       (com_sel),
    .write         (write),
    .read          (read),
    .adr           (adr),
    .synth_data_in (synth_data_in),
    .regdata_out   (regdata_out),
    .out_valid     (out_valid),
    .out_voice     (out_voice),
    .out_pitch     (out_pitch),
    .gliding       (gliding)
  );

  always #5 reg_clk = ~reg_clk;

  // Slot the next rising edge will process, tracked independently of the DUT.
  always @(posedge reg_clk) nextSlot <= reset ? 0 : (nextSlot + 1) % VOICES;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, required);
    end
  endtask

  always @(negedge reg_clk) begin : monitor
    exp_t e;
    if (!reset && out_valid === 1'b1 && sb.size() > 0) begin
      if (out_voice == sb[0].voice) begin
        e = sb.pop_front();
        checkOutput({e.name, " pitch"}, 32'(out_pitch), 32'(e.pitch));
        checkOutput({e.name, " gliding"}, 32'(gliding[e.voice]), 32'(e.glide));
      end
    end
  end

  task automatic pushExpect(input logic [V_WIDTH-1:0] v, input logic [P_WIDTH-1:0] p,
                            input logic g, input string n);
    exp_t e;
    e.voice = v;
    e.pitch = p;
    e.glide = g;
    e.name  = n;
    sb.push_back(e);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(posedge reg_clk); #1;
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: pending=%0d required 0 (next %s)", sb.size(), sb[0].name);
      sb.delete();
    end
  endtask

  // Load a target; collide=1 lands it on the voice's own slot, otherwise on the slot after.
  task automatic applyStimulus(input logic [V_WIDTH-1:0] v, input logic [P_WIDTH-1:0] p,
                               input logic legato, input bit collide);
    int want = collide ? int'(v) : (int'(v) + 1) % VOICES;
    int guard = 0;
    while (nextSlot != want && guard < 2 * VOICES) begin
      @(posedge reg_clk); #1;
      guard++;
    end
    tgt_valid  = 1'b1;
    tgt_voice  = v;
    tgt_pitch  = p;
    tgt_legato = legato;
    @(posedge reg_clk); #1;
    tgt_valid  = 1'b0;
    tgt_legato = 1'b0;
  endtask

  task automatic busWrite(input logic [6:0] a, input logic [7:0] d);
    com_sel = 1'b1; write = 1'b1; adr = a; synth_data_in = d;
    @(posedge reg_clk); #1;
    com_sel = 1'b0; write = 1'b0;
  endtask

  task automatic busRead(input logic [6:0] a, input logic [7:0] required, input string name);
    com_sel = 1'b1; read = 1'b1; adr = a;
    @(posedge reg_clk); #1;
    com_sel = 1'b0; read = 1'b0;
    checkOutput(name, 32'(regdata_out), 32'(required));
  endtask

  initial begin
    #1000000;
    checks++;
    errors++;
    $display("[TB] FAIL watchdog: time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    $display("[TB] start");
    repeat (2) @(posedge reg_clk);
    #1;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_pitch", 32'(out_pitch), 32'd0);
    checkOutput("reset gliding", 32'(gliding), 32'd0);
    checkOutput("reset regdata_out", 32'(regdata_out), 32'd0);

    // Loads and writes while reset is high must have no effect.
    tgt_valid = 1'b1; tgt_voice = 3'd0; tgt_pitch = 24'h000123;
    com_sel = 1'b1; write = 1'b1; adr = 7'd8; synth_data_in = 8'h05;
    @(posedge reg_clk); #1;
    tgt_valid = 1'b0; com_sel = 1'b0; write = 1'b0;
    reset = 1'b0;
    checkOutput("first cycle out_valid", 32'(out_valid), 32'd0);

    for (int i = 0; i < 20; i++) begin
      @(posedge reg_clk); #1;
      checkOutput("idle out_valid", 32'(out_valid), 32'd1);
      checkOutput("idle out_voice", 32'(out_voice), 32'(i % VOICES));
      checkOutput("idle out_pitch", 32'(out_pitch), 32'd0);
      checkOutput("idle gliding", 32'(gliding), 32'd0);
    end
    busRead(7'd8, 8'h00, "glide_time after reset");
    busRead(7'd9, 8'h00, "glide_mode after reset");

    busWrite(7'd8, 8'hFA);
    busWrite(7'd9, 8'h02);
    busRead(7'd8, 8'h0A, "read glide_time");
    busRead(7'd9, 8'h02, "read glide_mode");
    busRead(7'd10, 8'h02, "read unmapped holds");
    busWrite(7'd10, 8'h07);
    busRead(7'd8, 8'h0A, "write unmapped ignored");

    busWrite(7'd8, 8'h03);
    busWrite(7'd9, 8'h00);
    applyStimulus(3'd3, 24'h000100, 1'b0, 1'b0);
    pushExpect(3'd3, 24'h000100, 1'b0, "mode0 first load");
    waitDrain(40);
    applyStimulus(3'd3, 24'h100000, 1'b0, 1'b0);
    pushExpect(3'd3, 24'h100000, 1'b0, "mode0 jump");
    waitDrain(40);
    busWrite(7'd9, 8'h03);
    applyStimulus(3'd3, 24'h000200, 1'b1, 1'b0);
    pushExpect(3'd3, 24'h000200, 1'b0, "mode3 jump");
    waitDrain(40);

    busWrite(7'd8, 8'h02);
    busWrite(7'd9, 8'h01);
    applyStimulus(3'd1, 24'h000400, 1'b0, 1'b0);
    pushExpect(3'd1, 24'h000400, 1'b0, "glide first load");
    waitDrain(40);
    applyStimulus(3'd1, 24'h000800, 1'b0, 1'b0);
    for (int i = 0; i < 26; i++) begin
      pushExpect(3'd1, glideSeq[i], (glideSeq[i] != 24'h000800), "glide tc2");
    end
    waitDrain(260);

    busWrite(7'd8, 8'h04);
    applyStimulus(3'd6, 24'h000003, 1'b0, 1'b0);
    pushExpect(3'd6, 24'h000003, 1'b0, "down first load");
    waitDrain(40);
    applyStimulus(3'd6, 24'h000000, 1'b0, 1'b0);
    pushExpect(3'd6, 24'h000002, 1'b1, "down min step a");
    pushExpect(3'd6, 24'h000001, 1'b1, "down min step b");
    pushExpect(3'd6, 24'h000000, 1'b0, "down reach zero");
    pushExpect(3'd6, 24'h000000, 1'b0, "down hold zero");
    waitDrain(60);

    busWrite(7'd9, 8'h02);
    applyStimulus(3'd5, 24'h001000, 1'b0, 1'b0);
    pushExpect(3'd5, 24'h001000, 1'b0, "legato first load");
    waitDrain(40);
    applyStimulus(3'd5, 24'h002000, 1'b0, 1'b0);
    pushExpect(3'd5, 24'h002000, 1'b0, "legato off jumps");
    waitDrain(40);
    applyStimulus(3'd5, 24'h003000, 1'b1, 1'b0);
    pushExpect(3'd5, 24'h002100, 1'b1, "legato glide a");
    pushExpect(3'd5, 24'h0021F0, 1'b1, "legato glide b");
    waitDrain(40);

    busWrite(7'd8, 8'h0A);
    applyStimulus(3'd2, 24'h004000, 1'b0, 1'b0);
    pushExpect(3'd2, 24'h004000, 1'b0, "collide setup");
    waitDrain(40);
    applyStimulus(3'd2, 24'h008000, 1'b1, 1'b1);
    pushExpect(3'd2, 24'h004000, 1'b1, "collide glide no step");
    pushExpect(3'd2, 24'h004010, 1'b1, "collide next step");
    waitDrain(40);
    applyStimulus(3'd2, 24'h009000, 1'b0, 1'b1);
    pushExpect(3'd2, 24'h009000, 1'b0, "collide jump");
    waitDrain(40);

    busWrite(7'd8, 8'h04);
    busWrite(7'd9, 8'h01);
    applyStimulus(3'd4, 24'h000100, 1'b0, 1'b0);
    pushExpect(3'd4, 24'h000100, 1'b0, "abort setup");
    waitDrain(40);
    applyStimulus(3'd4, 24'h000900, 1'b0, 1'b0);
    pushExpect(3'd4, 24'h000180, 1'b1, "abort glide step");
    waitDrain(40);
    reset = 1'b1;
    repeat (2) @(posedge reg_clk);
    #1;
    checkOutput("midreset out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset out_pitch", 32'(out_pitch), 32'd0);
    checkOutput("midreset gliding", 32'(gliding), 32'd0);
    checkOutput("midreset regdata_out", 32'(regdata_out), 32'd0);
    reset = 1'b0;
    pushExpect(3'd4, 24'h000000, 1'b0, "voice4 cleared");
    waitDrain(40);
    busWrite(7'd8, 8'h04);
    busWrite(7'd9, 8'h01);
    applyStimulus(3'd4, 24'h000050, 1'b1, 1'b0);
    pushExpect(3'd4, 24'h000050, 1'b0, "post reset jump");
    waitDrain(40);
    busWrite(7'd8, 8'h00);
    applyStimulus(3'd4, 24'h007050, 1'b1, 1'b0);
    pushExpect(3'd4, 24'h007050, 1'b0, "time0 full step");
    waitDrain(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pitch_glide.md
PITCH_GLIDE -- requirements
Module: pitch_glide

Interface
REQ-001 Parameter VOICES, default 8, sets the number of voice channels.
REQ-002 Parameter V_WIDTH, default 3, sets the voice index width; VOICES SHALL be at most 2^V_WIDTH.
REQ-003 Parameter P_WIDTH, default 24, sets the pitch word (phase increment) width.
REQ-004 Port reg_clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-005 Port reset, input, 1 bit: reset is synchronous and active-high.
REQ-006 Port tgt_valid, input, 1 bit: loads a new target pitch.
REQ-007 Port tgt_voice, input, V_WIDTH bits: the voice being loaded.
REQ-008 Port tgt_pitch, input, P_WIDTH bits, unsigned: the new target pitch.
REQ-009 Port tgt_legato, input, 1 bit: the new note overlaps a held note.
REQ-010 Ports com_sel, write and read, inputs, 1 bit each: register bus strobes.
REQ-011 Port adr, input, 7 bits: register address.
REQ-012 Port synth_data_in, input, 8 bits: register write data.
REQ-013 Port regdata_out, output, 8 bits: registered read data.
REQ-014 Port out_valid, output, 1 bit: out_voice and out_pitch are valid.
REQ-015 Port out_voice, output, V_WIDTH bits: the voice index of out_pitch.
REQ-016 Port out_pitch, output, P_WIDTH bits: the current slewed pitch of out_voice.
REQ-017 Port gliding, output, VOICES bits: bit v is 1 when the current pitch of voice v differs from its target.

Function
REQ-018 Registers SHALL be: glide_time[3:0] at com_sel adr 8, and glide_mode[1:0] at com_sel adr 9; mode 0 = off, 1 = always glide, 2 = legato-only, 3 = treated as off.
REQ-019 A write with com_sel high SHALL update the addressed register from the low bits of synth_data_in on the same edge; other addresses SHALL be ignored.
REQ-020 A read with com_sel high at adr 8 or 9 SHALL drive regdata_out on the next edge, zero-extended; other addresses SHALL leave regdata_out unchanged.
REQ-021 Per-voice state SHALL be cur[v], tgt[v] and init[v].
REQ-022 A slot counter vcnt SHALL advance 0..VOICES-1 every cycle, wrapping to 0; slot vcnt processes voice vcnt.
REQ-023 Step rule: d = tgt - cur (signed); s = |d| >> glide_time; s = 1 if s = 0 and d != 0; cur moves toward tgt by s; d = 0 gives no change.
REQ-024 The step arithmetic SHALL be P_WIDTH+1 bits signed and SHALL never overshoot tgt.
REQ-025 glide_time = 0 SHALL make the step equal |d| (jump in one visit).
REQ-026 Output timing: on the edge after slot v is processed, out_valid = 1, out_voice = v, out_pitch = updated cur[v]; latency is 1 cycle; the first valid output follows the first post-reset edge.
REQ-027 On tgt_valid: tgt[tgt_voice] ← tgt_pitch and init[tgt_voice] ← 1.
REQ-028 On that load, cur also ← tgt_pitch if any of: mode is off/3; init was 0; mode 2 with tgt_legato = 0.
REQ-029 Otherwise the voice glides from its existing cur.
REQ-030 Collision (tgt_valid for the voice being processed that cycle): the load SHALL take priority; no step is applied that cycle; out_pitch SHALL show cur after the load rules.
REQ-031 Writes to glide_time or glide_mode mid-glide SHALL take effect on the next processed slot; no state is cleared.
REQ-032 gliding SHALL be registered and updated on each slot write and each target load.

Reset
REQ-033 While reset is high: cur, tgt and init of all voices, glide_time, glide_mode, vcnt, out_voice, out_pitch, out_valid, gliding and regdata_out SHALL all be 0; tgt_valid, write and read SHALL be ignored.
REQ-034 Reset asserted mid-glide SHALL abort the glide; the first load after reset SHALL jump per REQ-028.

Verification
REQ-035 Reset, then idle 20 cycles -> out_valid is 0 in the first cycle, then 1 with out_voice 0,1,..,7,0,..; out_pitch = 0; gliding = 0.
REQ-036 Mode 0, load voice 3 = 0x100000 -> the next voice-3 output is 0x100000 and gliding[3] is 0.
REQ-037 Mode 1, glide_time 2, voice 1 first loaded 0x000400, then 0x000800 -> voice-1 outputs are 0x000500, 0x0005C0, 0x000650, ..., then unit steps to 0x000800; gliding[1] falls at equality.
REQ-038 Mode 1, glide_time 4, cur 0x000003, target 0 -> outputs 0x000002, 0x000001, 0x000000 (minimum step, no undershoot).
REQ-039 Mode 2, voice 5 at 0x1000: load 0x2000 with legato = 0 -> jumps; then load 0x3000 with legato = 1 -> glides.
REQ-040 Write adr 8 = 0x0A and adr 9 = 0x02, then read both -> regdata_out is 0x0A, then 0x02; a tgt_valid coinciding with its own slot -> that slot's output follows REQ-030.
